fwft_prefetch_reader: RTL and testbench

//  Read-side front end for a standard (non-FWFT) single-clock FIFO whose read data returns RD_LATENCY cycles after fifo_rden.

---
 rtl/fwft_prefetch_reader.sv | 151 +++++++++++++++
 tb/tb_fwft_prefetch_reader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fwft_prefetch_reader.sv
// fwft_prefetch_reader
// Turns a fixed-latency standard FIFO read port into a first-word-fall-through
// interface. Reads are issued speculatively into a small circular buffer of
// RD_LATENCY+1 entries, which is the minimum that sustains one word per clock.
// Every issued read is tracked in a shift register until its data returns, so
// the buffer can never overflow.
// Legal RD_LATENCY values are 1..3.

module fwft_prefetch_reader #(
    parameter int  WIDTH      = 8,
    parameter int  RD_LATENCY = 1,
    localparam int BUF_DEPTH  = RD_LATENCY + 1,
    localparam int CNT_W      = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             fifo_empty,
    output logic             fifo_rden,
    input  logic [WIDTH-1:0] fifo_rdata,
    input  logic             rden,
    output logic [WIDTH-1:0] rdata,
    output logic             rdata_vld,
    output logic [CNT_W-1:0] buf_cnt
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    // Wide enough to hold buf_cnt + popcount(inflight) + 1 without wrapping.
    localparam int SUM_W = CNT_W + 2;

    // Read-tracking state: one bit per cycle of read latency.
    logic [RD_LATENCY-1:0] inflight_q;
    logic [RD_LATENCY-1:0] inflight_d;
    // Marks in-flight reads issued before a flush; their data is dropped.
    logic [RD_LATENCY-1:0] discard_q;
    logic [RD_LATENCY-1:0] discard_d;

    // Buffer state.
    logic [WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Per-cycle control.
    logic             pop;
    logic             pop_eff;
    logic             wr_en;
    logic [SUM_W-1:0] inflight_cnt;
    logic [SUM_W-1:0] occupancy;
    logic [SUM_W-1:0] limit;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // FWFT presentation straight from registered storage.
    assign rdata_vld = (cnt_q != '0);
    assign rdata     = mem_q[rd_ptr_q];
    assign buf_cnt   = cnt_q;

    // A pop only happens when a word is presented; flush overrides it.
    assign pop     = rden & rdata_vld;
    assign pop_eff = pop & ~flush;

    // Returning data is kept unless it belongs to a read issued before a flush,
    // or it lands in the flush cycle itself.
    assign wr_en = inflight_q[RD_LATENCY-1] & ~discard_q[RD_LATENCY-1] & ~flush;

    // Count reads still on their way back from the upstream FIFO.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + SUM_W'(inflight_q[i]);
        end
    end

    // Issue a read only if the word is guaranteed a buffer slot when it lands.
    // Comparing against BUF_DEPTH + pop avoids an unsigned subtraction.
    assign occupancy = SUM_W'(cnt_q) + inflight_cnt;
    assign limit     = SUM_W'(BUF_DEPTH) + SUM_W'(pop);
    assign fifo_rden = rst & ~flush & ~fifo_empty & (occupancy < limit);

    // Head of the tracking shift registers: new read enters, nothing discarded.
    assign inflight_d[0] = fifo_rden;
    assign discard_d[0]  = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < RD_LATENCY; gi++) begin : g_track
            assign inflight_d[gi] = inflight_q[gi-1];
            // On flush every read still in flight becomes a discard.
            assign discard_d[gi]  = flush ? inflight_q[gi-1] : discard_q[gi-1];
        end
    endgenerate

    // Pointer and count next-state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (pop_eff) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (wr_en) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            unique case ({wr_en, pop_eff})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control registers: tracking shift registers, pointers and count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Prefetch storage; cleared on reset so rdata reads zero when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= fifo_rdata;
        end
    end

endmodule

// File: tb/tb_fwft_prefetch_reader.sv
// Testbench for fwft_prefetch_reader with RD_LATENCY=2.
// A behavioural standard FIFO feeds the DUT; stimulus pushes expected words into
// a queue and a negedge monitor pops and compares on every consumer pop.
`timescale 1ns/1ps

module tb_fwft_prefetch_reader;

    localparam int W  = 8;
    localparam int L  = 2;
    localparam int BD = L + 1;
    localparam int CW = $clog2(BD + 1);

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          flush = 1'b0;
    logic          rden  = 1'b0;
    logic          fifo_empty;
    logic          fifo_rden;
    logic [W-1:0]  fifo_rdata;
    logic [W-1:0]  rdata;
    logic          rdata_vld;
    logic [CW-1:0] buf_cnt;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    // Upstream standard FIFO: data issued at edge N is presented after edge N+L-1.
    logic [W-1:0] up_mem [2048];
    int           up_wr = 0;
    int           up_rd = 0;
    logic [W-1:0] stage [L];

    assign fifo_empty = (up_rd == up_wr);
    assign fifo_rdata = stage[L-1];

    always @(posedge clk) begin
        if (fifo_rden) begin
            stage[0] <= up_mem[up_rd];
            up_rd    <= up_rd + 1;
        end else begin
            stage[0] <= 8'hEE;
        end
        for (int i = 1; i < L; i++) stage[i] <= stage[i-1];
    end

    fwft_prefetch_reader #(.WIDTH(W), .RD_LATENCY(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_rden  (fifo_rden),
        .fifo_rdata (fifo_rdata),
        .rden       (rden),
        .rdata      (rdata),
        .rdata_vld  (rdata_vld),
        .buf_cnt    (buf_cnt)
    );

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: invariants every cycle, scoreboard compare on every pop.
    always @(negedge clk) begin
        if (rst) begin
            chk("rden_while_empty", int'(fifo_rden & fifo_empty), 0);
            chk("buf_cnt_bound", int'(buf_cnt <= CW'(BD)), 1);
            if (rdata_vld && rden && !flush) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word_qsize", exp_q.size(), 1);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    pops++;
                    $display("pop %0d: rdata=%02h expected=%02h", pops, rdata, e);
                    chk("rdata_order", int'(rdata), int'(e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int base, input int n, input bit push);
        for (int i = 0; i < n; i++) begin
            logic [W-1:0] v;
            v = W'(base + i);
            up_mem[up_wr] = v;
            up_wr++;
            if (push) exp_q.push_back(v);
        end
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        int rd_cnt, rd_first, rd_last, v_cnt, v_first, v_last;

        repeat (3) @(posedge clk);
        #3 rst = 1'b1;

        // 1: idle with empty upstream
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("idle_fifo_rden", int'(fifo_rden), 0);
            chk("idle_vld", int'(rdata_vld), 0);
            chk("idle_buf_cnt", int'(buf_cnt), 0);
        end
        chk("idle_rdata", int'(rdata), 0);

        // 2: stream 0..255 with rden tied high
        rden = 1'b1;
        load(0, 256, 1'b1);
        #1;
        rd_cnt = 0; rd_first = -1; rd_last = -1;
        v_cnt = 0;  v_first = -1;  v_last = -1;
        for (int c = 0; c < 300; c++) begin
            if (fifo_rden) begin
                rd_cnt++;
                if (rd_first < 0) rd_first = c;
                rd_last = c;
            end
            if (rdata_vld) begin
                v_cnt++;
                if (v_first < 0) v_first = c;
                v_last = c;
            end
            @(posedge clk);
            #2;
        end
        chk("stream_rden_first", rd_first, 0);
        chk("stream_rden_count", rd_cnt, 256);
        chk("stream_rden_last", rd_last, 255);
        chk("stream_vld_first", v_first, 3);
        chk("stream_vld_count", v_cnt, 256);
        chk("stream_vld_last", v_last, 258);
        drain(10, "stream_drained");
        rden = 1'b0;

        // 3: backpressure then release
        tick();
        load(0, 8, 1'b1);
        repeat (10) tick();
        chk("bp_buf_cnt", int'(buf_cnt), 3);
        chk("bp_fifo_rden", int'(fifo_rden), 0);
        chk("bp_vld", int'(rdata_vld), 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_rdata_stable", int'(rdata), 0);
            chk("bp_cnt_stable", int'(buf_cnt), 3);
        end
        rden = 1'b1;
        drain(50, "bp_drained");
        repeat (2) tick();
        chk("bp_end_vld", int'(rdata_vld), 0);
        chk("bp_end_cnt", int'(buf_cnt), 0);
        chk("bp_end_fifo_rden", int'(fifo_rden), 0);
        rden = 1'b0;

        // 4: random consumer, 1024 incrementing bytes
        tick();
        load(0, 1024, 1'b1);
        for (int n = 0; n < 20000 && exp_q.size() != 0; n++) begin
            rden = 1'($urandom_range(0, 1));
            tick();
        end
        chk("rand_drained", exp_q.size(), 0);
        rden = 1'b0;
        repeat (4) tick();
        chk("rand_upstream_empty", up_wr - up_rd, 0);

        // 5: flush with 1 word buffered and 2 in flight; 0x40..0x42 are dropped
        tick();
        load(8'h40, 10, 1'b0);
        for (int i = 3; i < 10; i++) exp_q.push_back(W'(8'h40 + i));
        repeat (3) tick();
        chk("pre_flush_cnt", int'(buf_cnt), 1);
        chk("pre_flush_rdata", int'(rdata), 8'h40);
        flush = 1'b1;
        #1;
        chk("flush_fifo_rden", int'(fifo_rden), 0);
        tick();
        flush = 1'b0;
        chk("post_flush_vld", int'(rdata_vld), 0);
        chk("post_flush_cnt", int'(buf_cnt), 0);
        rden = 1'b1;
        drain(60, "flush_drained");
        repeat (4) tick();
        chk("flush_upstream_empty", up_wr - up_rd, 0);

        // 6: async reset pulse mid-stream; A2..A4 are lost, stream resumes at A5
        tick();
        load(8'hA0, 20, 1'b0);
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'hA1);
        for (int i = 5; i < 20; i++) exp_q.push_back(W'(8'hA0 + i));
        repeat (5) tick();
        #2;
        rst = 1'b0;
        #0.5;
        chk("arst_fifo_rden", int'(fifo_rden), 0);
        chk("arst_vld", int'(rdata_vld), 0);
        chk("arst_cnt", int'(buf_cnt), 0);
        chk("arst_rdata", int'(rdata), 0);
        #0.5;
        rst = 1'b1;
        drain(100, "arst_drained");
        rden = 1'b0;
        repeat (4) tick();
        chk("arst_end_vld", int'(rdata_vld), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound the whole run in case the DUT stalls.
    initial begin
        #500000;
        errors++;
        checks++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
